// File: rtl/fadd_pipe.sv
// fadd_pipe: 3-stage pipelined float add/sub with valid/ready backpressure.
// Optional flags port {invalid, overflow, flushed} enabled by FADD_FLAGS_EN.
module fadd_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y
`ifdef FADD_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  localparam int FW = 1 + EW + MW;
  localparam int LW = $clog2(MW + 5);
  localparam logic [FW-1:0] QNAN =
    {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  typedef struct packed {
    logic          spec;
    logic [FW-1:0] spec_y;
    logic          inv;
    logic          sign;
    logic [EW-1:0] exp;
    logic          sub;
    logic [MW+2:0] ms;
    logic [MW+2:0] mi;
  } s1_t;

  typedef struct packed {
    logic          spec;
    logic [FW-1:0] spec_y;
    logic          inv;
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW+3:0] sum;
    logic [LW-1:0] lzc;
  } s2_t;

  s1_t s1_q, s1_d, n1;
  s2_t s2_q, s2_d, n2;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [FW-1:0] y_q, y_d;
  logic [2:0] f_q, f_d;
  logic en1, en2, en3;

  assign en3 = !v3_q || out_ready;
  assign en2 = !v2_q || en3;
  assign en1 = !v1_q || en2;
  assign in_ready = en1;
  assign out_valid = v3_q;
  assign y = y_q;

  always_comb begin
    v1_d = en1 ? in_valid : v1_q;
    v2_d = en2 ? v1_q : v2_q;
    v3_d = en3 ? v2_q : v3_q;
  end

  logic s_a, s_b, z_a, z_b, inf_a, inf_b, nan_a, nan_b, swap;
  logic [EW-1:0] e_a, e_b, es, ei, ediff;
  logic [MW-1:0] m_a, m_b, ms, mi;
  int sh;

  assign s_a = x1[FW-1];
  assign s_b = x2[FW-1] ^ op_sub;
  assign e_a = x1[FW-2:MW];
  assign e_b = x2[FW-2:MW];
  assign m_a = x1[MW-1:0];
  assign m_b = x2[MW-1:0];

  always_comb begin
    z_a = e_a == '0;
    z_b = e_b == '0;
    inf_a = (&e_a) && (m_a == '0);
    inf_b = (&e_b) && (m_b == '0);
    nan_a = (&e_a) && (m_a != '0);
    nan_b = (&e_b) && (m_b != '0);
    swap = {e_b, m_b} > {e_a, m_a};
    es = swap ? e_b : e_a;
    ei = swap ? e_a : e_b;
    ms = swap ? m_b : m_a;
    mi = swap ? m_a : m_b;
    ediff = es - ei;
    sh = (int'(ediff) > MW + 4) ? MW + 4 : int'(ediff);
    n1 = '0;
    n1.sign = swap ? s_b : s_a;
    n1.exp = es;
    n1.sub = s_a ^ s_b;
    n1.ms = {1'b1, ms, 2'b00};
    n1.mi = {1'b1, mi, 2'b00} >> sh;
    if (nan_a || nan_b || (inf_a && inf_b && (s_a != s_b))) begin
      n1.spec = 1'b1;
      n1.spec_y = QNAN;
      n1.inv = 1'b1;
    end else if (inf_a) begin
      n1.spec = 1'b1;
      n1.spec_y = x1;
    end else if (inf_b) begin
      n1.spec = 1'b1;
      n1.spec_y = {s_b, x2[FW-2:0]};
    end else if (z_a && z_b) begin
      n1.spec = 1'b1;
      n1.spec_y = {s_a & s_b, {(FW-1){1'b0}}};
    end else if (z_a) begin
      n1.spec = 1'b1;
      n1.spec_y = {s_b, x2[FW-2:0]};
    end else if (z_b) begin
      n1.spec = 1'b1;
      n1.spec_y = x1;
    end
    s1_d = en1 ? n1 : s1_q;
  end

  always_comb begin
    n2 = '0;
    n2.spec = s1_q.spec;
    n2.spec_y = s1_q.spec_y;
    n2.inv = s1_q.inv;
    n2.sign = s1_q.sign;
    n2.exp = s1_q.exp;
    n2.sum = s1_q.sub ? {1'b0, s1_q.ms} - {1'b0, s1_q.mi}
                      : {1'b0, s1_q.ms} + {1'b0, s1_q.mi};
    n2.lzc = LW'(MW + 4);
    for (int i = 0; i < MW + 4; i++)
      if (n2.sum[i]) n2.lzc = LW'(MW + 3 - i);
    s2_d = en2 ? n2 : s2_q;
  end

  logic [MW:0]   norm_hi;
  logic          norm_g;
  logic [MW+1:0] mant_r;
  logic [MW-1:0] man_o;
  logic [FW-1:0] res_y;
  logic [2:0]    res_f;
  int e_res;

  always_comb begin
    {norm_hi, norm_g} = (MW+2)'((s2_q.sum << s2_q.lzc) >> 2);
    mant_r = {1'b0, norm_hi} + {{(MW+1){1'b0}}, norm_g};
    e_res = int'(s2_q.exp) + 1 - int'(s2_q.lzc) + int'(mant_r[MW+1]);
    man_o = mant_r[MW+1] ? mant_r[MW:1] : mant_r[MW-1:0];
    res_y = '0;
    res_f = '0;
    if (s2_q.spec) begin
      res_y = s2_q.spec_y;
      res_f = {s2_q.inv, 2'b00};
    end else if (s2_q.sum == '0) begin
      res_y = '0;
    end else if (e_res <= 0) begin
      res_y = {s2_q.sign, {(FW-1){1'b0}}};
      res_f = 3'b001;
    end else if (e_res >= (1 << EW) - 1) begin
      res_y = {s2_q.sign, {EW{1'b1}}, {MW{1'b0}}};
      res_f = 3'b010;
    end else begin
      res_y = {s2_q.sign, EW'(e_res), man_o};
    end
    y_d = en3 ? res_y : y_q;
    f_d = en3 ? res_f : f_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      y_q  <= '0;
      f_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      y_q  <= y_d;
      f_q  <= f_d;
    end
  end

`ifdef FADD_FLAGS_EN
  assign flags = f_q;
`else
  logic unused_flags;
  assign unused_flags = ^f_q;
`endif

endmodule
